time_entry: RTL
===============

# time_entry

Keypad-side front end for the microwave countdown timer. Collects BCD digits into a four-digit MM:SS entry buffer, then parallel-loads the mod-10 down-counter chain through its `data`/`loadn` interface. It gates the chain's `en`, watches the chain's all-zero flag, and reports completion. It is the writer/controller for the counter chain, which is the reader of this block's load bus.

## Interface
Parameters:
- `DONE_CYCLES`, default 3: number of cycles `done` stays high after the countdown reaches zero (1..15).

Ports:
- `clk` input 1: rising-edge clock.
- `clrn` input 1: asynchronous active-low reset.
- `digit` input 4: BCD keypad digit.
- `digit_valid` input 1: one-cycle strobe qualifying `digit`.
- `start` input 1: one-cycle start/resume strobe.
- `stop` input 1: one-cycle pause/cancel strobe.
- `chain_zero` input 1: all-zero flag from the counter chain (AND of the per-digit `zero` outputs).
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` output 4 each: load data for the four counters.
- `loadn` output 1: active-low parallel load to all counters.
- `en` output 1: count enable to the chain.
- `done` output 1: countdown-finished indication.
- `busy` output 1: high in LOAD, RUN and PAUSE.

## Operation
- FSM states: IDLE, LOAD, RUN, PAUSE, DONE. Reset state is IDLE.
- **IDLE:**
  - A `digit_valid` pulse with `digit`≤9 shifts the buffer left one digit: min_tens←min_ones←sec_tens←sec_ones←digit. The old min_tens is discarded.
  - `digit`>9 is ignored.
  - `start` with a non-zero buffer → LOAD. `start` with an all-zero buffer is ignored.
  - `stop` clears the buffer to 0000.
- **Clamp on start:** if sec_tens>5, the buffer is rewritten to sec_tens=5, sec_ones=9 in the same edge that enters LOAD.
- **LOAD:** `loadn`=0 for exactly one cycle with the buffer on the data outputs. Then → RUN unconditionally.
- **RUN:**
  - `en`=1.
  - `chain_zero`=1 → DONE.
  - Else `stop` → PAUSE.
  - `start` is ignored.
- **PAUSE:**
  - `en`=0.
  - `start` → RUN with no reload.
  - `stop` → IDLE with the buffer cleared.
  - Digits are ignored.
- **DONE:**
  - `done`=1 and `en`=0 for DONE_CYCLES cycles, then → IDLE with the buffer cleared.
  - All inputs are ignored.
- **Priority:**
  - `start` over `digit_valid` in IDLE; the digit is dropped.
  - `chain_zero` over `stop` in RUN.
  - `start` over `stop` in PAUSE.
- Data outputs always reflect the buffer; they are meaningful to the chain only while `loadn`=0.

## Timing
- All outputs are registered. Reset values: data outputs 0000, `loadn`=1, `en`=0, `done`=0, `busy`=0.
- A digit strobed at edge k is visible on the outputs after edge k.
- `start` sampled at edge k (IDLE): `loadn`=0 in the cycle after k, and `en`=1 from the cycle after k+1. The counters load on the edge that ends LOAD.
- `chain_zero` is sampled only in RUN. The first RUN cycle already sees the freshly loaded, non-zero value.
- RUN→DONE: `en` drops in the cycle after the edge that samples `chain_zero`=1. No extra decrement reaches the chain, because counters hold at zero.
- `stop` in RUN at edge k: `en`=0 from the cycle after k.
- Reset mid-operation forces IDLE and all reset values immediately (asynchronously), and clears the buffer.
- The done counter is a 4-bit down-counter loaded with DONE_CYCLES on DONE entry. It exits on the edge where it reads 1.

## Structure
- Shared package `microwave_pkg` holds:
  - the state enum (IDLE, LOAD, RUN, PAUSE, DONE);
  - `BCD_MAX`=9;
  - `SEC_TENS_MAX`=5;
  - `CLAMP_SEC_ONES`=9.
- Sub-module `bcd_entry_shift` holds the four 4-bit digit registers. It has inputs shift, digit, clear and clamp, with digit validation inside. The FSM, done counter and output registers live in `time_entry`.

## Test plan
- **Entry and clamp:** after reset, strobe digits 1,2,7,5 → buffer 1275. Strobe 0xA → unchanged. Pulse `start` → sec_tens/sec_ones become 5/9, `loadn`=0 for one cycle with data 1,2,5,9, then `en`=1.
- **Empty start:** reset, `start` with no digits → stays IDLE, `loadn` stays 1, `en` stays 0, `busy` stays 0.
- **Run to zero:** enter 0003 and start. Drive `chain_zero`=1 three cycles after `en` rises → `en`=0 in the next cycle, `done`=1 for exactly 3 cycles, then IDLE with buffer 0000.
- **Pause/resume/cancel:**
  - During RUN, `stop` → `en`=0 next cycle, `busy`=1.
  - `start` → `en`=1 again with no `loadn` pulse.
  - `stop`, `stop` → IDLE and buffer 0000.
- **Simultaneous events:**
  - `stop` and `chain_zero` in the same RUN cycle → DONE, not PAUSE.
  - `digit_valid` and `start` together in IDLE → LOAD with the pre-strobe buffer.
- **Async reset mid-RUN:** assert `clrn`=0 between edges → `en`=0, `busy`=0, data 0000 immediately. After release the block is in IDLE.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave timer front end.
// Holds the controller state encoding and BCD entry limits.
package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSE,
        DONE
    } state_e;

    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX   = 4'd5;
    localparam logic [3:0] CLAMP_SEC_ONES = 4'd9;

endpackage

// File: rtl/bcd_entry_shift.sv
// Four-digit MM:SS entry buffer with left-shift digit entry,
// clear, and seconds clamp applied when a countdown is launched.
module bcd_entry_shift
    import microwave_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       shift_i,
    input  logic [3:0] digit_i,
    input  logic       clear_i,
    input  logic       clamp_i,
    output logic [3:0] min_tens_o,
    output logic [3:0] min_ones_o,
    output logic [3:0] sec_tens_o,
    output logic [3:0] sec_ones_o
);

    logic [3:0] mt_q, mt_d;
    logic [3:0] mo_q, mo_d;
    logic [3:0] st_q, st_d;
    logic [3:0] so_q, so_d;

    always_comb begin
        mt_d = mt_q;
        mo_d = mo_q;
        st_d = st_q;
        so_d = so_q;
        if (clear_i) begin
            mt_d = '0;
            mo_d = '0;
            st_d = '0;
            so_d = '0;
        end else if (clamp_i) begin
            if (st_q > SEC_TENS_MAX) begin
                st_d = SEC_TENS_MAX;
                so_d = CLAMP_SEC_ONES;
            end
        end else if (shift_i && (digit_i <= BCD_MAX)) begin
            // Non-BCD key codes never reach the buffer.
            mt_d = mo_q;
            mo_d = st_q;
            st_d = so_q;
            so_d = digit_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mt_q <= '0;
            mo_q <= '0;
            st_q <= '0;
            so_q <= '0;
        end else begin
            mt_q <= mt_d;
            mo_q <= mo_d;
            st_q <= st_d;
            so_q <= so_d;
        end
    end

    assign min_tens_o = mt_q;
    assign min_ones_o = mo_q;
    assign sec_tens_o = st_q;
    assign sec_ones_o = so_q;

endmodule

// File: rtl/time_entry.sv
// Keypad front end: collects MM:SS digits, loads the down-counter
// chain, gates its enable and reports completion.
module time_entry
    import microwave_pkg::*;
#(
    parameter int unsigned DONE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       start,
    input  logic       stop,
    input  logic       chain_zero,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       loadn,
    output logic       en,
    output logic       done,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       loadn_q, en_q, done_q, busy_q;
    logic       shift, clear, clamp, nz;

    assign nz = |{min_tens, min_ones, sec_tens, sec_ones};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift   = 1'b0;
        clear   = 1'b0;
        clamp   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && nz) begin
                    state_d = LOAD;
                    clamp   = 1'b1;
                end else if (stop) begin
                    clear = 1'b1;
                end else if (digit_valid && !start) begin
                    shift = 1'b1;
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                if (chain_zero) begin
                    state_d = DONE;
                    cnt_d   = 4'(DONE_CYCLES);
                end else if (stop) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (start) begin
                    state_d = RUN;
                end else if (stop) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end
            end
            DONE: begin
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            loadn_q <= 1'b1;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loadn_q <= (state_d != LOAD);
            en_q    <= (state_d == RUN);
            done_q  <= (state_d == DONE);
            busy_q  <= (state_d == LOAD) || (state_d == RUN)
                    || (state_d == PAUSE);
        end
    end

    assign loadn = loadn_q;
    assign en    = en_q;
    assign done  = done_q;
    assign busy  = busy_q;

    bcd_entry_shift u_buf (
        .clk_i      (clk),
        .rst_ni     (clrn),
        .shift_i    (shift),
        .digit_i    (digit),
        .clear_i    (clear),
        .clamp_i    (clamp),
        .min_tens_o (min_tens),
        .min_ones_o (min_ones),
        .sec_tens_o (sec_tens),
        .sec_ones_o (sec_ones)
    );

endmodule
